// File: rtl/mmio_console.sv
`default_nettype none
// ============================================================================
// Module   : mmio_console
// Purpose  : Console and exit peripheral sitting on the core's data-memory
//            write channel. Writes to PUTC_ADDR are queued in a TX FIFO and
//            sent out as 8N1 UART frames. A write to EXIT_ADDR records an exit
//            code. Once every queued byte has left the line, a sticky exit
//            flag is raised. Writes to any other address are forwarded to the
//            data RAM.
// Revision : 1.0 - initial release
//
// Ports    : clk          core clock; all state changes on the rising edge
//            reset        synchronous, active-high reset
//            dmem_wready  core write request for the current cycle
//            dmem_waddr   write byte-address
//            dmem_wdata   write data
//            dmem_wstrb   byte strobes (only meaningful to the data RAM)
//            dmem_wvalid  write accepted this cycle (combinational)
//            mem_wready   write request forwarded to the data RAM (comb.)
//            uart_tx      serial output, idle high (registered)
//            exit_valid   sticky program-terminated flag (registered)
//            exit_code    data written to EXIT_ADDR (registered)
//            fifo_level   current TX FIFO occupancy (registered)
//
// Macro    : MMIO_CONSOLE_SIM_EN - when defined, each accepted PUTC byte is
//            echoed with $write, and the rise of exit_valid prints the exit
//            code and ends the simulation. When undefined the module contains
//            no system tasks at all.
// ============================================================================
module mmio_console #(
    parameter logic [31:0] PUTC_ADDR  = 32'h8000001c,
    parameter logic [31:0] EXIT_ADDR  = 32'h8000002c,
    parameter int          FIFO_DEPTH = 16,
    parameter int          CLK_DIV    = 868
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          dmem_wready,
    input  logic [31:0]                   dmem_waddr,
    input  logic [31:0]                   dmem_wdata,
    input  logic [3:0]                    dmem_wstrb,
    output logic                          dmem_wvalid,
    output logic                          mem_wready,
    output logic                          uart_tx,
    output logic                          exit_valid,
    output logic [31:0]                   exit_code,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_lw = c_aw + 1;
    localparam int c_dw = $clog2(CLK_DIV);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [7:0]      fifo_mem_q [FIFO_DEPTH];
    logic [c_aw-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_lw-1:0] level_q,  level_d;

    tx_state_t       state_q,  state_d;
    logic [c_dw-1:0] div_q,    div_d;
    logic [2:0]      bit_q,    bit_d;
    logic [7:0]      shift_q,  shift_d;
    logic            tx_q,     tx_d;

    logic            exit_pending_q, exit_pending_d;
    logic            exit_valid_q,   exit_valid_d;
    logic [31:0]     exit_code_q,    exit_code_d;

    // ------------------------------------------------------------------------
    // Decode and write handshake
    // ------------------------------------------------------------------------
    logic w_is_putc, w_is_exit, w_is_mmio;
    logic w_full, w_empty, w_accept, w_push, w_pop, w_div_end;

    // Strobes only matter to the RAM; the console takes the low byte as-is.
    logic w_unused_strb;
    assign w_unused_strb = ^dmem_wstrb;

    assign w_is_putc = (dmem_waddr == PUTC_ADDR);
    assign w_is_exit = (dmem_waddr == EXIT_ADDR);
    assign w_is_mmio = w_is_putc | w_is_exit;

    // Full is taken from the registered level, so a pop happening in the
    // same cycle never makes room for a push in that cycle.
    assign w_full  = (level_q == c_lw'(FIFO_DEPTH));
    assign w_empty = (level_q == '0);

    // The core is frozen as soon as an exit has been requested.
    assign dmem_wvalid = !(exit_pending_q | exit_valid_q) && !(w_is_putc && w_full);
    assign w_accept    = dmem_wready & dmem_wvalid;
    assign mem_wready  = w_accept & ~w_is_mmio;
    assign w_push      = w_accept & w_is_putc;

    assign w_div_end   = (div_q == c_dw'(CLK_DIV - 1));

    // ------------------------------------------------------------------------
    // TX FSM next-state and serial output
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        w_pop   = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    shift_d = fifo_mem_q[rd_ptr_q];
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (w_div_end) begin
                    div_d   = '0;
                    state_d = S_DATA;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_DATA: begin
                tx_d = shift_q[0];
                if (w_div_end) begin
                    div_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (w_div_end) begin
                    div_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FIFO pointers, level and exit bookkeeping
    // ------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        level_d        = level_q;
        exit_pending_d = exit_pending_q;
        exit_code_d    = exit_code_q;
        exit_valid_d   = exit_valid_q;

        // Pointers are exactly c_aw bits wide, so they wrap modulo the depth.
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (w_accept && w_is_exit) begin
            exit_pending_d = 1'b1;
            exit_code_d    = dmem_wdata;
        end
        // Exit only once the line has drained completely.
        if (exit_pending_q && w_empty && (state_q == S_IDLE)) begin
            exit_valid_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            state_q        <= S_IDLE;
            div_q          <= '0;
            bit_q          <= '0;
            shift_q        <= '0;
            tx_q           <= 1'b1;
            exit_pending_q <= 1'b0;
            exit_valid_q   <= 1'b0;
            exit_code_q    <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            state_q        <= state_d;
            div_q          <= div_d;
            bit_q          <= bit_d;
            shift_q        <= shift_d;
            tx_q           <= tx_d;
            exit_pending_q <= exit_pending_d;
            exit_valid_q   <= exit_valid_d;
            exit_code_q    <= exit_code_d;
        end
    end

    // Storage needs no reset: contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem_q[wr_ptr_q] <= dmem_wdata[7:0];
        end
    end

`ifdef MMIO_CONSOLE_SIM_EN
    always @(posedge clk) begin
        if (!reset && w_push) begin
            $write("%c", dmem_wdata[7:0]);
        end
        if (!reset && exit_valid_d && !exit_valid_q) begin
            $display("mmio_console: exit code %0d (0x%08h)", exit_code_q, exit_code_q);
            $finish(1);
        end
    end
`else
`endif

    assign uart_tx    = tx_q;
    assign exit_valid = exit_valid_q;
    assign exit_code  = exit_code_q;
    assign fifo_level = level_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_console.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_console
// Purpose  : Directed, self-checking bench for mmio_console built with
//            FIFO_DEPTH=4 and CLK_DIV=4. A serial receiver process decodes
//            frames from uart_tx for the multi-byte scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_console;

    localparam logic [31:0] PUTC = 32'h8000001c;
    localparam logic [31:0] EXIT = 32'h8000002c;

    logic        clk = 1'b0;
    logic        reset;
    logic        dmem_wready;
    logic [31:0] dmem_waddr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_wvalid;
    logic        mem_wready;
    logic        uart_tx;
    logic        exit_valid;
    logic [31:0] exit_code;
    logic [2:0]  fifo_level;

    int n_cmp = 0;
    int n_bad = 0;

    mmio_console #(
        .PUTC_ADDR  (PUTC),
        .EXIT_ADDR  (EXIT),
        .FIFO_DEPTH (4),
        .CLK_DIV    (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .dmem_wready (dmem_wready),
        .dmem_waddr  (dmem_waddr),
        .dmem_wdata  (dmem_wdata),
        .dmem_wstrb  (dmem_wstrb),
        .dmem_wvalid (dmem_wvalid),
        .mem_wready  (mem_wready),
        .uart_tx     (uart_tx),
        .exit_valid  (exit_valid),
        .exit_code   (exit_code),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Serial receiver: samples near the middle of each 4-cycle bit.
    // ------------------------------------------------------------------------
    logic       mon_en = 1'b0;
    logic [7:0] rx_q[$];
    int         rx_stop_err = 0;

    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && uart_tx === 1'b0) begin
                repeat (5) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    b[k] = uart_tx;
                    if (k < 7) repeat (4) @(negedge clk);
                end
                repeat (4) @(negedge clk);
                if (uart_tx !== 1'b1) rx_stop_err++;
                rx_q.push_back(b);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, actual=running required=done");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (no checking)
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        dmem_wready = 1'b1;
        dmem_waddr  = a;
        dmem_wdata  = d;
        dmem_wstrb  = s;
    endtask

    task automatic idle_bus();
        dmem_wready = 1'b0;
        dmem_waddr  = 32'h0;
        dmem_wdata  = 32'h0;
        dmem_wstrb  = 4'h0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        idle_bus();
        do_reset(2);
        n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL rst_tx: got %b want 1", uart_tx); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
        n_cmp++; if (exit_valid !== 1'b0) begin n_bad++; $display("FAIL rst_exit_valid: got %b want 0", exit_valid); end
        n_cmp++; if (exit_code !== 32'h0) begin n_bad++; $display("FAIL rst_exit_code: got %h want 0", exit_code); end

        // 0x55 goes on the line, 0x33 stays buffered; reset mid-frame.
        drive_write(PUTC, 32'h55, 4'h1); tick();   // edge N
        drive_write(PUTC, 32'h33, 4'h1); tick();   // edge N+1
        idle_bus();
        repeat (9) tick();                         // edge N+10: data bit1 of 0x55 = 0
        n_cmp++; if (uart_tx !== 1'b0) begin n_bad++; $display("FAIL midframe_tx: got %b want 0", uart_tx); end
        reset = 1'b1;
        tick();
        n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL abort_tx: got %b want 1", uart_tx); end
        tick(); tick();
        reset = 1'b0;
        n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL rst3_tx: got %b want 1", uart_tx); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL rst3_level: got %0d want 0", fifo_level); end
        n_cmp++; if (exit_valid !== 1'b0) begin n_bad++; $display("FAIL rst3_exit_valid: got %b want 0", exit_valid); end
        n_cmp++; if (exit_code !== 32'h0) begin n_bad++; $display("FAIL rst3_exit_code: got %h want 0", exit_code); end
        // The buffered byte must have been discarded.
        for (int i = 0; i < 20; i++) begin
            n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL discard_tx[%0d]: got %b want 1", i, uart_tx); end
            tick();
        end
    endtask

    task automatic test_single_byte();
        logic [9:0] line;
        line = {1'b1, 8'hA5, 1'b0};
        drive_write(PUTC, 32'h000000A5, 4'h1);
        #1;
        n_cmp++; if (mem_wready !== 1'b0) begin n_bad++; $display("FAIL putc_mem_wready: got %b want 0", mem_wready); end
        n_cmp++; if (dmem_wvalid !== 1'b1) begin n_bad++; $display("FAIL putc_wvalid: got %b want 1", dmem_wvalid); end
        tick();                                    // edge N
        idle_bus();
        n_cmp++; if (fifo_level !== 3'd1) begin n_bad++; $display("FAIL single_level_n: got %0d want 1", fifo_level); end
        n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL single_tx_n: got %b want 1", uart_tx); end
        tick();                                    // edge N+1: popped
        n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL single_level_n1: got %0d want 0", fifo_level); end
        n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL single_tx_n1: got %b want 1", uart_tx); end
        tick();                                    // edge N+2: start bit
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < 4; c++) begin
                n_cmp++;
                if (uart_tx !== line[i]) begin
                    n_bad++;
                    $display("FAIL single_line bit%0d cyc%0d: got %b want %b", i, c, uart_tx, line[i]);
                end
                tick();
            end
        end
        n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL single_idle_after: got %b want 1", uart_tx); end
    endtask

    task automatic test_pass_through();
        drive_write(32'h00020010, 32'h12345678, 4'b1100);
        #1;
        n_cmp++; if (mem_wready !== 1'b1) begin n_bad++; $display("FAIL pass_mem_wready: got %b want 1", mem_wready); end
        n_cmp++; if (dmem_wvalid !== 1'b1) begin n_bad++; $display("FAIL pass_wvalid: got %b want 1", dmem_wvalid); end
        dmem_wready = 1'b0;
        #1;
        n_cmp++; if (mem_wready !== 1'b0) begin n_bad++; $display("FAIL pass_noreq_mem_wready: got %b want 0", mem_wready); end
        n_cmp++; if (dmem_wvalid !== 1'b1) begin n_bad++; $display("FAIL pass_noreq_wvalid: got %b want 1", dmem_wvalid); end
        dmem_wready = 1'b1;
        tick();
        idle_bus();
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL pass_level[%0d]: got %0d want 0", i, fifo_level); end
            n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL pass_tx[%0d]: got %b want 1", i, uart_tx); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] lvl_before [5];
        int stall;
        int waited;
        lvl_before = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3};
        rx_q.delete();
        rx_stop_err = 0;
        mon_en = 1'b1;
        for (int b = 0; b < 5; b++) begin
            drive_write(PUTC, 32'h41 + b, 4'h1);
            #1;
            n_cmp++; if (fifo_level !== lvl_before[b]) begin n_bad++; $display("FAIL bp_level[%0d]: got %0d want %0d", b, fifo_level, lvl_before[b]); end
            n_cmp++; if (dmem_wvalid !== 1'b1) begin n_bad++; $display("FAIL bp_wvalid[%0d]: got %b want 1", b, dmem_wvalid); end
            tick();
        end
        drive_write(PUTC, 32'h46, 4'h1);
        #1;
        n_cmp++; if (fifo_level !== 3'd4) begin n_bad++; $display("FAIL bp_full_level: got %0d want 4", fifo_level); end
        n_cmp++; if (dmem_wvalid !== 1'b0) begin n_bad++; $display("FAIL bp_full_wvalid: got %b want 0", dmem_wvalid); end
        stall = 0;
        while (dmem_wvalid !== 1'b1 && stall < 200) begin
            stall++;
            tick();
        end
        // Pop of 0x41's successor happens in a cycle where level is still 4,
        // so the push is only accepted the cycle after, from level 3.
        n_cmp++; if (stall !== 38) begin n_bad++; $display("FAIL bp_stall_cycles: got %0d want 38", stall); end
        n_cmp++; if (fifo_level !== 3'd3) begin n_bad++; $display("FAIL bp_level_on_accept: got %0d want 3", fifo_level); end
        tick();
        idle_bus();
        n_cmp++; if (fifo_level !== 3'd4) begin n_bad++; $display("FAIL bp_level_refill: got %0d want 4", fifo_level); end
        waited = 0;
        while (rx_q.size() < 6 && waited < 600) begin
            waited++;
            tick();
        end
        n_cmp++; if (rx_q.size() !== 6) begin n_bad++; $display("FAIL bp_rx_count: got %0d want 6", rx_q.size()); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (i >= rx_q.size() || rx_q[i] !== 8'(8'h41 + i)) begin
                n_bad++;
                $display("FAIL bp_rx_byte[%0d]: got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, 8'(8'h41 + i));
            end
        end
        n_cmp++; if (rx_stop_err !== 0) begin n_bad++; $display("FAIL bp_stop_bits: got %0d bad want 0", rx_stop_err); end
        repeat (10) tick();
        mon_en = 1'b0;
        n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL bp_drained: got %0d want 0", fifo_level); end
    endtask

    task automatic test_exit_drain();
        int k;
        drive_write(PUTC, 32'h0000000A, 4'h1); tick();   // edge E1
        drive_write(EXIT, 32'h00000003, 4'hF); tick();   // edge E2
        idle_bus();
        n_cmp++; if (dmem_wvalid !== 1'b0) begin n_bad++; $display("FAIL drain_pending_wvalid: got %b want 0", dmem_wvalid); end
        n_cmp++; if (exit_valid !== 1'b0) begin n_bad++; $display("FAIL drain_early_exit: got %b want 0", exit_valid); end
        k = 2;
        while (exit_valid !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        // Frame starts at E2, STOP ends at E42, exit seen one cycle later.
        n_cmp++; if (k !== 43) begin n_bad++; $display("FAIL drain_exit_edge: got E%0d want E43", k); end
        n_cmp++; if (exit_code !== 32'h3) begin n_bad++; $display("FAIL drain_exit_code: got %h want 3", exit_code); end
        n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL drain_tx_idle: got %b want 1", uart_tx); end
        drive_write(32'h00000100, 32'hDEADBEEF, 4'hF);
        #1;
        n_cmp++; if (dmem_wvalid !== 1'b0) begin n_bad++; $display("FAIL post_exit_ram_wvalid: got %b want 0", dmem_wvalid); end
        n_cmp++; if (mem_wready !== 1'b0) begin n_bad++; $display("FAIL post_exit_mem_wready: got %b want 0", mem_wready); end
        drive_write(PUTC, 32'h41, 4'h1);
        #1;
        n_cmp++; if (dmem_wvalid !== 1'b0) begin n_bad++; $display("FAIL post_exit_putc_wvalid: got %b want 0", dmem_wvalid); end
        tick();
        idle_bus();
        n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL post_exit_level: got %0d want 0", fifo_level); end
        repeat (5) tick();
        n_cmp++; if (exit_valid !== 1'b1) begin n_bad++; $display("FAIL drain_sticky: got %b want 1", exit_valid); end
    endtask

    task automatic test_exit_empty();
        do_reset(2);
        n_cmp++; if (exit_valid !== 1'b0) begin n_bad++; $display("FAIL empty_rst_exit: got %b want 0", exit_valid); end
        drive_write(EXIT, 32'h0, 4'hF);
        #1;
        n_cmp++; if (dmem_wvalid !== 1'b1) begin n_bad++; $display("FAIL empty_exit_wvalid: got %b want 1", dmem_wvalid); end
        tick();                                    // accept edge N
        idle_bus();
        n_cmp++; if (exit_valid !== 1'b0) begin n_bad++; $display("FAIL empty_exit_n: got %b want 0", exit_valid); end
        tick();                                    // edge N+1
        n_cmp++; if (exit_valid !== 1'b1) begin n_bad++; $display("FAIL empty_exit_n1: got %b want 1", exit_valid); end
        n_cmp++; if (exit_code !== 32'h0) begin n_bad++; $display("FAIL empty_exit_code: got %h want 0", exit_code); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (exit_valid !== 1'b1) begin n_bad++; $display("FAIL empty_sticky[%0d]: got %b want 1", i, exit_valid); end
        end
        do_reset(1);
        n_cmp++; if (exit_valid !== 1'b0) begin n_bad++; $display("FAIL empty_cleared: got %b want 0", exit_valid); end
    endtask

    initial begin
        reset = 1'b1;
        idle_bus();
        test_reset();
        test_single_byte();
        test_pass_through();
        test_backpressure();
        test_exit_drain();
        test_exit_empty();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
